// File: rtl/spec_frame_sink_pkg.sv
// Shared defaults, FSM encoding and error-flag bit positions for the spectrum frame sink.
package spec_frame_sink_pkg;

  localparam int unsigned LenDefault = 8192;
  localparam int unsigned AwDefault  = 13;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StRecv   = 2'd1,
    StResync = 2'd2,
    StCommit = 2'd3
  } state_e;

  localparam int unsigned ErrShort = 0;
  localparam int unsigned ErrLong  = 1;
  localparam int unsigned ErrSop   = 2;

endpackage

// File: rtl/spec_frame_sink_frame_ram.sv
// Simple dual-port frame store: two banks of 2**AW words, one write port, registered read port.
module spec_frame_sink_frame_ram #(
  parameter int unsigned AW = 13
) (
  input  logic        nios_clk,
  input  logic        reset,
  input  logic        we,
  input  logic [AW:0] waddr,
  input  logic [31:0] wdata,
  input  logic [AW:0] raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [2**(AW+1)];
  logic [31:0] rdata_q;

  always_ff @(posedge nios_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge nios_clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spec_frame_sink.sv
// Avalon-ST spectrum sink: checks framing against LEN and publishes whole frames
// through a two-bank ping-pong buffer that the Nios reads and then releases.
module spec_frame_sink
  import spec_frame_sink_pkg::*;
#(
  parameter int unsigned LEN = LenDefault,
  parameter int unsigned AW  = AwDefault
) (
  input  logic          nios_clk,
  input  logic          reset,
  input  logic [31:0]   data,
  input  logic          nios_valid,
  input  logic          nios_sop,
  input  logic          nios_eop,
  input  logic [1:0]    nios_empty,
  output logic          nios_ready,
  output logic          frame_ready,
  output logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data,
  input  logic          rd_done,
  output logic [15:0]   err_cnt,
  output logic [2:0]    err_flags
);

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic          wr_bank_q;
  logic          rd_bank_q;
  logic [1:0]    full_q;
  logic [15:0]   err_cnt_q;
  logic [2:0]    err_flags_q;

  logic          beat;
  logic          last;
  logic          we;
  logic          rel;
  logic [AW-1:0] wr_off;
  logic [2:0]    err_set;
  logic [16:0]   err_sum;
  logic          unused_empty;

  assign unused_empty = ^nios_empty;

  // The write bank can only be full when both banks are, so this is the "both full" stall.
  assign nios_ready  = !reset && (state_q != StCommit) && !full_q[wr_bank_q];
  assign beat        = nios_valid && nios_ready;
  assign last        = (cnt_q == AW'(LEN - 1));
  assign we          = beat && (nios_sop || (state_q == StRecv));
  assign wr_off      = nios_sop ? '0 : cnt_q;
  assign rel         = rd_done && frame_ready;
  assign frame_ready = |full_q;
  assign rd_bank     = rd_bank_q;
  assign err_cnt     = err_cnt_q;
  assign err_flags   = err_flags_q;

  always_comb begin
    err_set = '0;
    if (beat && nios_sop && (state_q == StRecv)) begin
      err_set[ErrSop] = 1'b1;
    end
    if (beat && nios_sop && nios_eop) begin
      err_set[ErrShort] = 1'b1;
    end
    if (beat && !nios_sop && (state_q == StRecv)) begin
      if (nios_eop && !last) begin
        err_set[ErrShort] = 1'b1;
      end
      if (!nios_eop && last) begin
        err_set[ErrLong] = 1'b1;
      end
    end
    err_sum = {1'b0, err_cnt_q} + 17'(err_set[0]) + 17'(err_set[1]) + 17'(err_set[2]);
  end

  always_ff @(posedge nios_clk) begin
    if (reset) begin
      state_q     <= StHunt;
      cnt_q       <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      err_cnt_q   <= '0;
      err_flags_q <= '0;
    end else begin
      err_flags_q <= err_flags_q | err_set;
      err_cnt_q   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      // A release never targets the bank being committed, so both updates can coexist.
      if (rel) begin
        full_q[rd_bank_q] <= 1'b0;
        rd_bank_q         <= ~rd_bank_q;
      end
      if (state_q == StCommit) begin
        full_q[wr_bank_q] <= 1'b1;
        wr_bank_q         <= ~wr_bank_q;
        state_q           <= StHunt;
      end else if (beat) begin
        if (nios_sop) begin
          cnt_q   <= AW'(1);
          state_q <= nios_eop ? StHunt : StRecv;
        end else if (state_q == StRecv) begin
          if (nios_eop) begin
            state_q <= last ? StCommit : StHunt;
          end else if (last) begin
            state_q <= StResync;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end else if ((state_q == StResync) && nios_eop) begin
          state_q <= StHunt;
        end
      end
    end
  end

  spec_frame_sink_frame_ram #(
    .AW(AW)
  ) u_frame_ram (
    .nios_clk(nios_clk),
    .reset   (reset),
    .we      (we),
    .waddr   ({wr_bank_q, wr_off}),
    .wdata   (data),
    .raddr   ({rd_bank_q, rd_addr}),
    .rdata   (rd_data)
  );

endmodule

// File: tb/tb_spec_frame_sink.sv
// Bench for spec_frame_sink (LEN=8): table-driven framing cases, directed bank corner
// cases and a randomized stream checked against a frame-level reference model.
module tb_spec_frame_sink;

  localparam int unsigned LEN = 8;
  localparam int unsigned AW  = 3;

  logic          nios_clk   = 1'b0;
  logic          reset      = 1'b1;
  logic [31:0]   data       = '0;
  logic          nios_valid = 1'b0;
  logic          nios_sop   = 1'b0;
  logic          nios_eop   = 1'b0;
  logic [1:0]    nios_empty = 2'b00;
  logic          nios_ready;
  logic          frame_ready;
  logic          rd_bank;
  logic [AW-1:0] rd_addr    = '0;
  logic [31:0]   rd_data;
  logic          rd_done    = 1'b0;
  logic [15:0]   err_cnt;
  logic [2:0]    err_flags;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: frames are sop..eop runs of exactly LEN accepted words.
  logic [31:0] cur[$];
  logic [31:0] exp_q[$];
  bit          collecting;
  int          m_err;
  logic [2:0]  m_flags;
  bit          m_rd_bank;
  bit          wr_done;

  typedef struct {
    int         n;
    bit         sop;
    bit         eop;
    logic [2:0] flags;
    int         cnt;
  } vec_t;
  vec_t vecs[5];

  spec_frame_sink #(
    .LEN(LEN),
    .AW (AW)
  ) dut (
    .nios_clk   (nios_clk),
    .reset      (reset),
    .data       (data),
    .nios_valid (nios_valid),
    .nios_sop   (nios_sop),
    .nios_eop   (nios_eop),
    .nios_empty (nios_empty),
    .nios_ready (nios_ready),
    .frame_ready(frame_ready),
    .rd_bank    (rd_bank),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_done    (rd_done),
    .err_cnt    (err_cnt),
    .err_flags  (err_flags)
  );

  always #5 nios_clk = ~nios_clk;
  always @(posedge nios_clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time limit, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    cur.delete();
    exp_q.delete();
    collecting = 1'b0;
    m_err      = 0;
    m_flags    = '0;
    m_rd_bank  = 1'b0;
  endtask

  task automatic model_beat(input logic [31:0] d, input bit s, input bit e);
    if (s) begin
      if (collecting) begin
        m_flags[2] = 1'b1;
        m_err++;
      end
      cur.delete();
      cur.push_back(d);
      collecting = !e;
      if (e) begin
        m_flags[0] = 1'b1;
        m_err++;
      end
    end else if (collecting) begin
      cur.push_back(d);
      if (cur.size() == int'(LEN)) begin
        collecting = 1'b0;
        if (e) begin
          foreach (cur[i]) exp_q.push_back(cur[i]);
        end else begin
          m_flags[1] = 1'b1;
          m_err++;
        end
      end else if (e) begin
        collecting = 1'b0;
        m_flags[0] = 1'b1;
        m_err++;
      end
    end
  endtask

  task automatic send_word(input logic [31:0] d, input bit s, input bit e);
    int guard = 0;
    bit ok    = 1'b0;
    while (!ok && guard < 100) begin
      @(negedge nios_clk);
      data       = d;
      nios_valid = 1'b1;
      nios_sop   = s;
      nios_eop   = e;
      #1;
      if (nios_ready) ok = 1'b1;
      else guard++;
    end
    if (!ok) begin
      nios_valid = 1'b0;
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: nios_ready=0 for 100 cycles, want 1");
    end else begin
      model_beat(d, s, e);
    end
    @(posedge nios_clk);
    #1 nios_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] base, input int n, input bit s0, input bit elast,
                            input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 2)) @(negedge nios_clk);
      send_word(base + 32'(i), (i == 0) && s0, (i == n - 1) && elast);
    end
  endtask

  task automatic do_reset();
    @(negedge nios_clk);
    reset      = 1'b1;
    nios_valid = 1'b0;
    rd_done    = 1'b0;
    #1 check("ready_in_reset", 32'(nios_ready), 0);
    model_reset();
    @(negedge nios_clk);
    reset = 1'b0;
    #1;
    check("rst_nios_ready", 32'(nios_ready), 1);
    check("rst_frame_ready", 32'(frame_ready), 0);
    check("rst_rd_bank", 32'(rd_bank), 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_err_flags", 32'(err_flags), 0);
  endtask

  // Reads the oldest bank, compares against the model's oldest frame, optionally releases it.
  task automatic read_bank(input bit rel);
    int w = 0;
    @(negedge nios_clk);
    while (!frame_ready && w < 50) begin
      @(negedge nios_clk);
      w++;
    end
    n_cmp++;
    if (!frame_ready || exp_q.size() < int'(LEN)) begin
      n_bad++;
      $display("FAIL frame_avail: frame_ready=%0b queued_words=%0d, want 1 and %0d",
               frame_ready, exp_q.size(), LEN);
      return;
    end
    check("rd_bank", 32'(rd_bank), 32'(m_rd_bank));
    for (int i = 0; i < int'(LEN); i++) begin
      rd_addr = AW'(i);
      @(negedge nios_clk);
      check("rd_data", rd_data, exp_q[i]);
    end
    repeat (LEN) void'(exp_q.pop_front());
    m_rd_bank = ~m_rd_bank;
    if (rel) begin
      rd_done = 1'b1;
      @(negedge nios_clk);
      rd_done = 1'b0;
      #1;
    end
  endtask

  initial begin
    int good;
    int t;
    int start;
    vecs[0] = '{n: 0, sop: 1'b0, eop: 1'b0, flags: 3'b000, cnt: 0};
    vecs[1] = '{n: 3, sop: 1'b0, eop: 1'b1, flags: 3'b000, cnt: 0};
    vecs[2] = '{n: 5, sop: 1'b1, eop: 1'b1, flags: 3'b001, cnt: 1};
    vecs[3] = '{n: 9, sop: 1'b1, eop: 1'b1, flags: 3'b010, cnt: 1};
    vecs[4] = '{n: 2, sop: 1'b1, eop: 1'b0, flags: 3'b100, cnt: 1};

    // Malformed or dropped prefix followed by one clean frame; only that frame lands in bank 0.
    for (int k = 0; k < 5; k++) begin
      do_reset();
      if (vecs[k].n > 0) send_frame(32'hBAD0_0000, vecs[k].n, vecs[k].sop, vecs[k].eop, 1'b0);
      send_frame(32'h100 * 32'(k + 1), LEN, 1'b1, 1'b1, 1'b0);
      read_bank(1'b1);
      check("tbl_err_flags", 32'(err_flags), 32'(vecs[k].flags));
      check("tbl_err_cnt", 32'(err_cnt), 32'(vecs[k].cnt));
      check("tbl_model_cnt", 32'(err_cnt), 32'(m_err));
      check("tbl_single_frame", 32'(frame_ready), 0);
    end

    // Two back-to-back clean frames with data = bin index.
    do_reset();
    send_frame(32'h0, LEN, 1'b1, 1'b1, 1'b0);
    send_frame(32'h0, LEN, 1'b1, 1'b1, 1'b0);
    @(negedge nios_clk);
    #1 check("commit_ready_low", 32'(nios_ready), 0);
    @(negedge nios_clk);
    #1 check("two_frame_ready", 32'(frame_ready), 1);
    for (int i = 0; i < 3; i++) begin
      check("both_full_stall", 32'(nios_ready), 0);
      @(negedge nios_clk);
    end
    read_bank(1'b1);
    check("after_done_ready", 32'(nios_ready), 1);
    check("after_done_frame_ready", 32'(frame_ready), 1);
    check("after_done_rd_bank", 32'(rd_bank), 1);
    read_bank(1'b1);

    // Release of bank 0 lands in the same cycle as bank 1's commit.
    do_reset();
    send_frame(32'hA00, LEN, 1'b1, 1'b1, 1'b1);
    read_bank(1'b0);
    send_frame(32'hB00, LEN, 1'b1, 1'b1, 1'b1);
    @(negedge nios_clk);
    rd_done = 1'b1;
    #1 check("commit_cycle_ready", 32'(nios_ready), 0);
    @(negedge nios_clk);
    rd_done = 1'b0;
    #1;
    check("overlap_frame_ready", 32'(frame_ready), 1);
    check("overlap_rd_bank", 32'(rd_bank), 1);
    check("overlap_nios_ready", 32'(nios_ready), 1);
    read_bank(1'b1);
    check("overlap_drained", 32'(frame_ready), 0);

    // Reset in the middle of a frame with a full bank and a nonzero error count.
    do_reset();
    send_frame(32'h5000, 5, 1'b1, 1'b1, 1'b0);
    send_frame(32'h6000, LEN, 1'b1, 1'b1, 1'b0);
    @(negedge nios_clk);
    @(negedge nios_clk);
    #1;
    check("pre_rst_frame_ready", 32'(frame_ready), 1);
    check("pre_rst_err_cnt", 32'(err_cnt), 1);
    send_frame(32'h7000, 3, 1'b1, 1'b0, 1'b0);
    do_reset();
    send_frame(32'h8000, LEN, 1'b1, 1'b1, 1'b0);
    read_bank(1'b1);

    // Randomized stream with gaps and an independent reader.
    do_reset();
    wr_done = 1'b0;
    start   = cyc;
    fork
      begin
        good = 0;
        while (good < 6) begin
          t = int'($urandom_range(0, 5));
          case (t)
            3: send_frame($urandom, int'($urandom_range(1, LEN - 1)), 1'b1, 1'b1, 1'b1);
            4: send_frame($urandom, int'($urandom_range(LEN + 1, LEN + 3)), 1'b1, 1'b1, 1'b1);
            5: send_frame($urandom, int'($urandom_range(1, LEN - 1)), 1'b1, 1'b0, 1'b1);
            default: begin
              send_frame($urandom, LEN, 1'b1, 1'b1, 1'b1);
              good++;
            end
          endcase
        end
        wr_done = 1'b1;
      end
      begin
        while (!(wr_done && exp_q.size() == 0)) begin
          if (cyc - start > 20000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rand_drain: %0d words still expected after cycle budget, want 0",
                     exp_q.size());
            break;
          end
          @(negedge nios_clk);
          if (frame_ready) begin
            repeat ($urandom_range(0, 3)) @(negedge nios_clk);
            read_bank(1'b1);
          end
        end
      end
    join
    @(negedge nios_clk);
    #1;
    check("rand_no_extra_frame", 32'(frame_ready), 0);
    check("rand_err_cnt", 32'(err_cnt), 32'(m_err));
    check("rand_err_flags", 32'(err_flags), 32'(m_flags));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
